// File: rtl/bcd_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_pkg
// Description : Shared constants and leading-zero blank mask helper for the
//               8-digit BCD display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_display_pkg;

    localparam int N_DIGITS = 8;
    localparam int DIGIT_W  = 4;
    localparam int VALUE_W  = N_DIGITS * DIGIT_W;
    localparam int IDX_W    = 3;

    localparam logic [N_DIGITS-1:0] AN_OFF = 8'hFF;

    // Digit i is blanked when it and every digit to its left are zero.
    // Digit 0 always survives so a value of zero still shows "0".
    function automatic logic [N_DIGITS-1:0] lz_blank_mask(
        input logic [VALUE_W-1:0] value,
        input logic               lz_en
    );
        logic [N_DIGITS-1:0] mask;
        logic                all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (value[i*DIGIT_W +: DIGIT_W] == 4'd0);
            mask[i]  = lz_en & all_zero;
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_display_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scan_if
// Description : Load bus and display drive signals of the BCD display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_display_scan_if
    import bcd_display_pkg::*;
;
    logic                load;
    logic [VALUE_W-1:0]  value;
    logic [N_DIGITS-1:0] dp_in;
    logic [N_DIGITS-1:0] digit_en;
    logic                lz_blank;
    logic                load_ack;
    logic [DIGIT_W-1:0]  bcd;
    logic [N_DIGITS-1:0] an;
    logic                dp;

    modport master (
        output load, value, dp_in, digit_en, lz_blank,
        input  load_ack, bcd, an, dp
    );

    modport slave (
        input  load, value, dp_in, digit_en, lz_blank,
        output load_ack, bcd, an, dp
    );

endinterface
`default_nettype wire

// File: rtl/bcd_display_scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running prescaler; single-cycle tick every TICK_DIV clks.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 100_000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == c_LAST);
    assign o_tick = w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_scan
// Description : 8-digit multiplexed 7-segment scanner with tear-free
//               double-buffered load, digit enables, dp and zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_scan
    import bcd_display_pkg::*;
#(
    parameter int TICK_DIV = 100_000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bcd_display_scan_if.slave  bus
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_DIGITS - 1);

    logic                w_tick;
    logic                w_frame_end;
    logic [N_DIGITS-1:0] w_blank_mask;
    logic                w_blank;

    logic [IDX_W-1:0]    r_idx;
    logic                r_pend_flag;
    logic [VALUE_W-1:0]  r_pend_value;
    logic [N_DIGITS-1:0] r_pend_dp;
    logic [N_DIGITS-1:0] r_pend_en;
    logic                r_pend_lz;
    logic [VALUE_W-1:0]  r_act_value;
    logic [N_DIGITS-1:0] r_act_dp;
    logic [N_DIGITS-1:0] r_act_en;
    logic                r_act_lz;
    logic                r_load_ack;
    logic [DIGIT_W-1:0]  r_bcd;
    logic [N_DIGITS-1:0] r_an;
    logic                r_dp;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    assign w_frame_end  = w_tick & (r_idx == c_LAST_IDX);
    assign w_blank_mask = ~r_act_en | lz_blank_mask(r_act_value, r_act_lz);
    assign w_blank      = w_blank_mask[r_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Active data only changes on a frame boundary; a load arriving exactly
    // on the boundary bypasses the pending buffer so it is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_flag  <= 1'b0;
            r_pend_value <= '0;
            r_pend_dp    <= '0;
            r_pend_en    <= '0;
            r_pend_lz    <= 1'b0;
            r_act_value  <= '0;
            r_act_dp     <= '0;
            r_act_en     <= '0;
            r_act_lz     <= 1'b0;
            r_load_ack   <= 1'b0;
        end else begin
            r_load_ack <= 1'b0;
            if (w_frame_end) begin
                if (bus.load) begin
                    r_act_value <= bus.value;
                    r_act_dp    <= bus.dp_in;
                    r_act_en    <= bus.digit_en;
                    r_act_lz    <= bus.lz_blank;
                    r_pend_flag <= 1'b0;
                    r_load_ack  <= 1'b1;
                end else if (r_pend_flag) begin
                    r_act_value <= r_pend_value;
                    r_act_dp    <= r_pend_dp;
                    r_act_en    <= r_pend_en;
                    r_act_lz    <= r_pend_lz;
                    r_pend_flag <= 1'b0;
                    r_load_ack  <= 1'b1;
                end
            end else if (bus.load) begin
                r_pend_value <= bus.value;
                r_pend_dp    <= bus.dp_in;
                r_pend_en    <= bus.digit_en;
                r_pend_lz    <= bus.lz_blank;
                r_pend_flag  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd <= '0;
            r_an  <= AN_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_bcd <= r_act_value[r_idx*DIGIT_W +: DIGIT_W];
            r_an  <= w_blank ? AN_OFF : ~(N_DIGITS'(1) << r_idx);
            r_dp  <= w_blank | ~r_act_dp[r_idx];
        end
    end

    assign bus.load_ack = r_load_ack;
    assign bus.bcd      = r_bcd;
    assign bus.an       = r_an;
    assign bus.dp       = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_scan
// Description : Scoreboard bench for bcd_display_scan against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scan;
    import bcd_display_pkg::*;

    localparam int TD    = 4;
    localparam int FRAME = TD * 8;

    typedef struct packed {
        logic [3:0] bcd;
        logic [7:0] an;
        logic       dp;
        logic       ack;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_display_scan_if bus ();

    bcd_display_scan #(
        .TICK_DIV (TD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_edges = 0;

    // Reference state: what the display currently shows and what is queued.
    logic [31:0] m_val, p_val;
    logic [7:0]  m_dp, m_en, p_dp, p_en;
    logic        m_lz, p_lz, p_flag;

    function automatic bit m_blank(int i);
        if (!m_en[i]) return 1'b1;
        if (m_lz && i != 0) begin
            for (int j = i; j < 8; j++)
                if (((m_val >> (4 * j)) & 32'hF) != 0) return 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            n_edges = 0;
            m_val = '0; m_dp = '0; m_en = '0; m_lz = 1'b0;
            p_val = '0; p_dp = '0; p_en = '0; p_lz = 1'b0; p_flag = 1'b0;
        end else begin
            int   slot;
            bit   boundary;
            obs_t e;
            slot     = (n_edges / TD) % 8;
            boundary = ((n_edges % TD) == TD - 1) && (slot == 7);
            e.bcd    = 4'((m_val >> (4 * slot)) & 32'hF);
            e.an     = m_blank(slot) ? 8'hFF : ~(8'h01 << slot);
            e.dp     = m_blank(slot) ? 1'b1 : ~m_dp[slot];
            e.ack    = 1'b0;
            if (boundary && bus.load) begin
                m_val = bus.value; m_dp = bus.dp_in; m_en = bus.digit_en; m_lz = bus.lz_blank;
                p_flag = 1'b0;
                e.ack  = 1'b1;
            end else if (boundary && p_flag) begin
                m_val = p_val; m_dp = p_dp; m_en = p_en; m_lz = p_lz;
                p_flag = 1'b0;
                e.ack  = 1'b1;
            end else if (!boundary && bus.load) begin
                p_val = bus.value; p_dp = bus.dp_in; p_en = bus.digit_en; p_lz = bus.lz_blank;
                p_flag = 1'b1;
            end
            exp_q.push_back(e);
            n_edges++;
        end
    end

    always @(negedge clk) begin
        obs_t got, e;
        got = {bus.bcd, bus.an, bus.dp, bus.load_ack};
        if (!rst_n) begin
            e = {4'h0, 8'hFF, 1'b1, 1'b0};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_hold: got bcd=%h an=%h dp=%b ack=%b, expected bcd=%h an=%h dp=%b ack=%b",
                         got.bcd, got.an, got.dp, got.ack, e.bcd, e.an, e.dp, e.ack);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL scan t=%0t: got bcd=%h an=%h dp=%b ack=%b, expected bcd=%h an=%h dp=%b ack=%b",
                         $time, got.bcd, got.an, got.dp, got.ack, e.bcd, e.an, e.dp, e.ack);
            end
        end
    end

    // Waits (at negedges) until the next clock edge will be edge number
    // n_edges with n_edges % FRAME == pos.
    task automatic wait_frame_pos(input int pos);
        for (int t = 0; t < 4 * FRAME; t++) begin
            if ((n_edges % FRAME) == pos) return;
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_frame_pos: position %0d not reached, got edge %0d", pos, n_edges);
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] dpi,
                           input logic [7:0] en, input logic lz);
        bus.value    = v;
        bus.dp_in    = dpi;
        bus.digit_en = en;
        bus.lz_blank = lz;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
        bus.value    = 32'($urandom);
        bus.dp_in    = 8'($urandom);
        bus.digit_en = 8'($urandom);
        bus.lz_blank = 1'($urandom);
    endtask

    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    initial begin
        bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.digit_en = '0; bus.lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Scan order
        do_load(32'h8765_4321, 8'h00, 8'hFF, 1'b0);
        repeat (2 * FRAME + 4) @(negedge clk);

        // Tear-free commit from mid-frame, then last-wins double load
        wait_frame_pos(3 * TD);
        do_load(32'h1111_1111, 8'h00, 8'hFF, 1'b0);
        repeat (FRAME) @(negedge clk);
        wait_frame_pos(2 * TD);
        do_load(32'h2222_2222, 8'hFF, 8'hFF, 1'b0);
        wait_frame_pos(5 * TD + 1);
        do_load(32'h3333_3333, 8'h00, 8'hFF, 1'b0);
        repeat (FRAME) @(negedge clk);

        // Load exactly on the frame boundary
        wait_frame_pos(FRAME - 1);
        do_load(32'h9876_5432, 8'h10, 8'hFF, 1'b0);
        repeat (FRAME) @(negedge clk);

        // Leading-zero blanking
        do_load(32'h0000_0400, 8'h00, 8'hFF, 1'b1);
        repeat (2 * FRAME) @(negedge clk);
        do_load(32'h0000_0000, 8'h00, 8'hFF, 1'b1);
        repeat (2 * FRAME) @(negedge clk);

        // Digit enable and decimal point
        do_load(32'h1234_5678, 8'h02, 8'h0F, 1'b0);
        repeat (2 * FRAME) @(negedge clk);

        // Asynchronous reset in the middle of a slot
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_now("async_rst_an",  32'(bus.an),       32'hFF);
        check_now("async_rst_dp",  32'(bus.dp),       32'h1);
        check_now("async_rst_ack", 32'(bus.load_ack), 32'h0);
        check_now("async_rst_bcd", 32'(bus.bcd),      32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME) @(negedge clk);

        // Randomized traffic, biased toward leading zeros
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                logic [31:0] v;
                v = 32'($urandom) >> (4 * $urandom_range(0, 8));
                do_load(v, 8'($urandom),
                        ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF,
                        1'($urandom));
            end else begin
                @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
